// File: rtl/hart_arb_pkg.sv
// Shared types and helpers for the hart time-slot arbiter.
package hart_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } arb_state_e;

   localparam int unsigned STARVE_W = 16;

   // Select width for n harts; a single hart still needs one bit.
   function automatic int unsigned sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hart_rr_pick.sv
// Cyclic first-set finder: lowest set priority bit wins, else first mask bit
// at or after i_start, wrapping to index 0.
module hart_rr_pick
   import hart_arb_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]        i_mask,
   input  logic [sel_w(N)-1:0] i_start,
   input  logic [N-1:0]        i_prio,
   output logic [sel_w(N)-1:0] o_idx,
   output logic                o_valid
);
   localparam int unsigned SEL_W = sel_w(N);

   logic [N-1:0] w_pm;

   assign w_pm = i_mask & i_prio;

   // Later loops overwrite earlier ones, so the wrapped half is the fallback.
   always_comb begin
      o_idx   = '0;
      o_valid = |i_mask;
      if (|w_pm) begin
         for (int i = int'(N) - 1; i >= 0; i--)
            if (w_pm[i]) o_idx = SEL_W'(i);
      end else begin
         for (int i = int'(N) - 1; i >= 0; i--)
            if (i_mask[i] && (i < int'(i_start))) o_idx = SEL_W'(i);
         for (int i = int'(N) - 1; i >= 0; i--)
            if (i_mask[i] && (i >= int'(i_start))) o_idx = SEL_W'(i);
      end
   end

endmodule

// File: rtl/hart_slot_arbiter.sv
// Time-slot arbiter for the shared MMU/memory port with quantum, request skip
// and drain/switch handshake. Starvation monitor enabled by HART_SLOT_ARB_STARVE_EN.
module hart_slot_arbiter
   import hart_arb_pkg::*;
#(
   parameter int unsigned N_HARTS      = 2,
   parameter int unsigned QUANTUM      = 1,
   parameter int unsigned QW           = 8,
   parameter int unsigned STARVE_LIMIT = 1024
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [N_HARTS-1:0]          i_req,
   input  logic [N_HARTS-1:0]          i_safe,
   input  logic                        i_hold,
   input  logic                        i_pf_pend,
   output logic [sel_w(N_HARTS)-1:0]   o_sel,
   output logic [N_HARTS-1:0]          o_gnt,
   output logic [N_HARTS-1:0]          o_busy,
   output logic                        o_switch,
   output logic [QW-1:0]               o_qcnt,
   output logic [N_HARTS-1:0]          o_starve
);
   localparam int unsigned   SEL_W = sel_w(N_HARTS);
   localparam logic [QW-1:0] QMAX  = '1;
   localparam logic [QW-1:0] QLAST = QW'(QUANTUM - 1);

   arb_state_e         r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_nxt;
   logic [N_HARTS-1:0] r_gnt;
   logic               r_switch;
   logic [QW-1:0]      r_qcnt;

   logic [N_HARTS-1:0] w_sel_oh;
   logic [N_HARTS-1:0] w_others;
   logic [N_HARTS-1:0] w_prio;
   logic               w_cur_req;
   logic               w_cur_safe;
   logic               w_want;
   logic [SEL_W-1:0]   w_start;
   logic [SEL_W-1:0]   w_pick_idx;
   logic               w_pick_vld;

   assign w_sel_oh   = N_HARTS'(1) << r_sel;
   assign w_others   = i_req & ~w_sel_oh;
   assign w_cur_req  = |(i_req & w_sel_oh);
   assign w_cur_safe = |(i_safe & w_sel_oh);
   assign w_want     = ((r_qcnt >= QLAST) || !w_cur_req) && (|w_others);
   assign w_start    = (r_sel == SEL_W'(N_HARTS - 1)) ? '0 : r_sel + SEL_W'(1);

   hart_rr_pick #(
      .N (N_HARTS)
   ) u_pick (
      .i_mask  (w_others),
      .i_start (w_start),
      .i_prio  (w_prio),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_vld)
   );

   // Grant FSM: RUN counts the quantum, DRAIN waits for a safe point, SWITCH is the bubble.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= ST_RUN;
         r_sel    <= '0;
         r_nxt    <= '0;
         r_gnt    <= N_HARTS'(1);
         r_switch <= 1'b0;
         r_qcnt   <= '0;
      end else begin
         r_switch <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (!i_hold && (r_qcnt != QMAX)) r_qcnt <= r_qcnt + QW'(1);
               if (w_want) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!w_pick_vld) begin
                  r_state <= ST_RUN;
               end else if (w_cur_safe && !i_hold && !i_pf_pend) begin
                  r_state <= ST_SWITCH;
                  r_nxt   <= w_pick_idx;
                  r_gnt   <= '0;
               end
            end
            ST_SWITCH: begin
               r_state  <= ST_RUN;
               r_sel    <= r_nxt;
               r_gnt    <= N_HARTS'(1) << r_nxt;
               r_qcnt   <= '0;
               r_switch <= 1'b1;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

`ifdef HART_SLOT_ARB_STARVE_EN
   logic [N_HARTS-1:0][STARVE_W-1:0] r_wait;
   logic [N_HARTS-1:0]               r_starve;

   // Per-hart wait counters; a granted hart restarts from zero.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wait   <= '0;
         r_starve <= '0;
      end else begin
         for (int g = 0; g < int'(N_HARTS); g++) begin
            if (r_gnt[g])
               r_wait[g] <= '0;
            else if (i_req[g] && !i_hold && (r_wait[g] != '1))
               r_wait[g] <= r_wait[g] + STARVE_W'(1);
            r_starve[g] <= (32'(r_wait[g]) >= STARVE_LIMIT);
         end
      end
   end

   assign w_prio   = r_starve;
   assign o_starve = r_starve;
`else
   assign w_prio   = '0;
   assign o_starve = '0;
`endif

   assign o_sel    = r_sel;
   assign o_gnt    = r_gnt;
   assign o_busy   = ~r_gnt;
   assign o_switch = r_switch;
   assign o_qcnt   = r_qcnt;

endmodule
